merger_out_writer: RTL and testbench
====================================

MERGER_OUT_WRITER -- requirements
Module: merger_out_writer

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, record width in bits; P, default 4, records per input beat; LINE_BEATS, default 4, input beats per output line; BURST_SIZE, default 20, lines per write burst; ADDR_STEP, default 16, address increment per line in record units.
REQ-002 SHALL have ports, clock and reset first:
- i_clk  in  1  sole clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_start  in  1  one-cycle job start pulse.
- i_base_addr  in  32  first line address.
- i_num_lines  in  32  lines in the job.
- i_data  in  P*DATA_WIDTH  merger output FIFO head, first-word-fall-through.
- i_empty  in  1  merger output FIFO empty.
- o_read  out  1  merger output FIFO dequeue.
- o_wr_data  out  P*DATA_WIDTH*LINE_BEATS  packed line.
- o_wr_addr  out  32  line address.
- o_wr_valid  out  1  line valid.
- o_wr_last  out  1  last line of a burst.
- i_wr_ready  in  1  memory accepts the line.
- o_busy  out  1  job in progress.
- o_done  out  1  one-cycle job completion pulse.
- o_checksum  out  32  see REQ-020.

Function
REQ-003 SHALL implement states IDLE, FILL, WRITE and DONE.
REQ-004 IDLE: i_start SHALL latch i_base_addr into the address register, clear the line counter, and go to FILL; if i_num_lines==0, it SHALL go to DONE instead.
REQ-005 o_read SHALL equal (state==FILL) & ~i_empty, combinationally; it SHALL never assert in any other state.
REQ-006 On each o_read cycle, i_data SHALL be captured into beat slot b, bits [b*P*DATA_WIDTH +: P*DATA_WIDTH], where b is the beat counter, and the beat counter SHALL increment.
- Record 0 of beat 0 SHALL occupy the LSBs of the line.
REQ-007 On the capture of beat LINE_BEATS-1, the beat counter SHALL wrap to 0 and the next state SHALL be WRITE.
REQ-008 In WRITE, o_wr_valid SHALL be 1, and o_wr_data and o_wr_addr SHALL be held stable until the cycle with i_wr_ready=1.
REQ-009 o_wr_last SHALL be 1 in WRITE when (line counter mod BURST_SIZE)==BURST_SIZE-1, or when the line counter equals i_num_lines-1 (latched value).
REQ-010 On acceptance (WRITE & i_wr_ready):
- The address SHALL increase by ADDR_STEP, with 32-bit wrap-around.
- The line counter SHALL increment.
- If this was the final line, the next state SHALL be DONE; otherwise FILL.
REQ-011 DONE SHALL last exactly one cycle with o_done=1, then go to IDLE.
REQ-012 o_busy SHALL be 1 in FILL and WRITE only.
REQ-013 i_start outside IDLE SHALL be ignored.
REQ-014 i_num_lines SHALL be latched at start; later changes SHALL have no effect on the running job.
REQ-015 i_empty=1 in FILL SHALL stall without losing partial beats; an arbitrary number of stall cycles SHALL be tolerated.
REQ-016 Minimum line period SHALL be LINE_BEATS+1 cycles: LINE_BEATS fill cycles plus one write cycle with i_wr_ready=1.

Reset
REQ-017 When i_rst_n=0 at a rising i_clk edge, state SHALL become IDLE, and the beat counter, line counter, address and checksum SHALL be cleared.
REQ-018 Reset outputs SHALL be: o_read=0, o_wr_valid=0, o_wr_last=0, o_busy=0, o_done=0, o_wr_addr=0, o_wr_data=0, o_checksum=0.
REQ-019 Reset mid-job SHALL discard any partial line and any unaccepted line; no o_done SHALL be issued.

Configuration
REQ-020 Macro MERGER_OUT_WRITER_CHECKSUM_EN:
- Defined: o_checksum SHALL accumulate the mod-2^32 sum of all DATA_WIDTH records of each line, updated on the acceptance cycle; it SHALL clear on i_start accepted in IDLE and remain valid through DONE and the following IDLE.
- Undefined: o_checksum SHALL be constant 0, and no accumulator logic SHALL be built.

Verification
REQ-021 Base 0x100, 2 lines, FIFO always non-empty, ready=1:
- Writes at cycles start+5 and start+10.
- Addresses 0x100 then 0x110.
- o_wr_last on line 1 only.
- o_done at start+11.
REQ-022 Beats 0x3_2_1_0, 0x7_6_5_4, 0xB_A_9_8, 0xF_E_D_C (records 0..15 in order) -> o_wr_data records 0..15 ascending from LSB; checksum 120 with the macro, 0 without.
REQ-023 45 lines, BURST_SIZE=20 -> o_wr_last on lines 19, 39 and 44 only; final address base+44*16.
REQ-024 i_wr_ready held 0 for 7 cycles in WRITE -> o_wr_data/o_wr_addr stable; o_read=0 throughout; no lost or duplicated line.
REQ-025 i_empty toggled randomly; i_start pulsed while busy; i_num_lines=0 job -> exact record order preserved; extra starts ignored; zero-length job gives o_done one cycle after start with no o_wr_valid.
REQ-026 Reset asserted after 2 beats of a line -> all outputs at reset values next cycle; a new 1-line job then writes only the post-reset beats.

Source files
------------

// File: rtl/merger_out_writer.sv
// Packs LINE_BEATS merger output beats into one wide line and writes lines out in bursts.
// Optional running record checksum is enabled by defining MERGER_OUT_WRITER_CHECKSUM_EN.
module merger_out_writer #(
   parameter int DATA_WIDTH = 32,
   parameter int P          = 4,
   parameter int LINE_BEATS = 4,
   parameter int BURST_SIZE = 20,
   parameter int ADDR_STEP  = 16
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic                              i_start,
   input  logic [31:0]                       i_base_addr,
   input  logic [31:0]                       i_num_lines,
   input  logic [P*DATA_WIDTH-1:0]           i_data,
   input  logic                              i_empty,
   output logic                              o_read,
   output logic [P*DATA_WIDTH*LINE_BEATS-1:0] o_wr_data,
   output logic [31:0]                       o_wr_addr,
   output logic                              o_wr_valid,
   output logic                              o_wr_last,
   input  logic                              i_wr_ready,
   output logic                              o_busy,
   output logic                              o_done,
   output logic [31:0]                       o_checksum
);

   localparam int BEAT_W   = P * DATA_WIDTH;
   localparam int LINE_W   = BEAT_W * LINE_BEATS;
   localparam int BEAT_CW  = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
   localparam int BURST_CW = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1;
   localparam logic [BEAT_CW-1:0]  LAST_BEAT     = BEAT_CW'(LINE_BEATS - 1);
   localparam logic [BURST_CW-1:0] LAST_IN_BURST = BURST_CW'(BURST_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      WRITE,
      DONE
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [LINE_W-1:0]   line_buf;
   logic [BEAT_CW-1:0]  beat_cnt;
   logic [BURST_CW-1:0] burst_cnt;
   logic [31:0]         line_cnt;
   logic [31:0]         addr;
   logic [31:0]         num_lines;
   logic                start_ok;
   logic                capture;
   logic                accept;
   logic                final_line;
   logic                line_last;

   assign start_ok   = (state == IDLE) && i_start;
   assign capture    = (state == FILL) && !i_empty;
   assign accept     = (state == WRITE) && i_wr_ready;
   assign final_line = (line_cnt == num_lines - 32'd1);
   // burst_cnt tracks line_cnt mod BURST_SIZE without a 32-bit divider
   assign line_last  = final_line || (burst_cnt == LAST_IN_BURST);

   assign o_wr_data = line_buf;
   assign o_wr_addr = addr;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      o_read     = 1'b0;
      o_wr_valid = 1'b0;
      o_wr_last  = 1'b0;
      o_busy     = 1'b0;
      o_done     = 1'b0;
      case (state)
         IDLE: begin
            if (i_start) begin
               state_next = (i_num_lines == 32'd0) ? DONE : FILL;
            end
         end
         FILL: begin
            o_busy = 1'b1;
            o_read = !i_empty;
            if (!i_empty && (beat_cnt == LAST_BEAT)) begin
               state_next = WRITE;
            end
         end
         WRITE: begin
            o_busy     = 1'b1;
            o_wr_valid = 1'b1;
            o_wr_last  = line_last;
            if (i_wr_ready) begin
               state_next = final_line ? DONE : FILL;
            end
         end
         DONE: begin
            o_done     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         line_buf  <= '0;
         beat_cnt  <= '0;
         burst_cnt <= '0;
         line_cnt  <= '0;
         addr      <= '0;
         num_lines <= '0;
      end else begin
         if (start_ok) begin
            addr      <= i_base_addr;
            num_lines <= i_num_lines;
            line_cnt  <= '0;
            burst_cnt <= '0;
            beat_cnt  <= '0;
         end
         if (capture) begin
            for (int b = 0; b < LINE_BEATS; b++) begin
               if (beat_cnt == BEAT_CW'(b)) begin
                  line_buf[b*BEAT_W +: BEAT_W] <= i_data;
               end
            end
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
         end
         if (accept) begin
            addr      <= addr + 32'(ADDR_STEP);
            line_cnt  <= line_cnt + 32'd1;
            burst_cnt <= (burst_cnt == LAST_IN_BURST) ? '0 : burst_cnt + 1'b1;
         end
      end
   end

`ifdef MERGER_OUT_WRITER_CHECKSUM_EN
   logic [31:0] checksum;
   logic [31:0] line_sum;

   always_comb begin
      line_sum = '0;
      for (int r = 0; r < P * LINE_BEATS; r++) begin
         line_sum = line_sum + 32'(line_buf[r*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   // Holds its value after the job so it can be read in DONE and the following IDLE
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         checksum <= '0;
      end else if (start_ok) begin
         checksum <= '0;
      end else if (accept) begin
         checksum <= checksum + line_sum;
      end
   end

   assign o_checksum = checksum;
`else
   assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_merger_out_writer.sv
// Randomized self-checking bench for merger_out_writer: a FIFO model feeds beats and a
// line-level reference model predicts every written line, address, burst flag and checksum.
module tb_merger_out_writer;

   localparam int DATA_WIDTH = 32;
   localparam int P          = 4;
   localparam int LINE_BEATS = 4;
   localparam int BURST_SIZE = 20;
   localparam int ADDR_STEP  = 16;
   localparam int BEAT_W     = P * DATA_WIDTH;
   localparam int LINE_W     = BEAT_W * LINE_BEATS;

   logic                clk = 1'b0;
   logic                rstN;
   logic                start;
   logic [31:0]         baseAddr;
   logic [31:0]         numLines;
   logic [BEAT_W-1:0]   fifoData;
   logic                fifoEmpty;
   logic                readOut;
   logic [LINE_W-1:0]   wrData;
   logic [31:0]         wrAddr;
   logic                wrValid;
   logic                wrLast;
   logic                wrReady;
   logic                busy;
   logic                done;
   logic [31:0]         checksum;

   always #5 clk = ~clk;

   merger_out_writer #(
      .DATA_WIDTH(DATA_WIDTH),
      .P(P),
      .LINE_BEATS(LINE_BEATS),
      .BURST_SIZE(BURST_SIZE),
      .ADDR_STEP(ADDR_STEP)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rstN),
      .i_start(start),
      .i_base_addr(baseAddr),
      .i_num_lines(numLines),
      .i_data(fifoData),
      .i_empty(fifoEmpty),
      .o_read(readOut),
      .o_wr_data(wrData),
      .o_wr_addr(wrAddr),
      .o_wr_valid(wrValid),
      .o_wr_last(wrLast),
      .i_wr_ready(wrReady),
      .o_busy(busy),
      .o_done(done),
      .o_checksum(checksum)
   );

   typedef struct {
      logic [LINE_W-1:0] data;
      logic [31:0]       addr;
      logic              last;
   } line_t;

   logic [BEAT_W-1:0] fifoQ[$];
   line_t             expQ[$];
   int                wrCycles[$];
   int                testsRun = 0;
   int                testsFailed = 0;
   int                cyc = 0;
   int                startCyc = 0;
   int                doneCount = 0;
   int                lastDoneCyc = 0;
   int                holdLen = 0;
   int                holdCnt = 0;
   int                stallPct = 0;
   int                readyPct = 100;
   bit                rdSeen = 0;
   bit                accSeen = 0;
   bit                prevDone = 0;
   bit                prevHeld = 0;
   bit                validSeen = 0;
   logic [LINE_W-1:0] heldData;
   logic [31:0]       heldAddr;
   logic [31:0]       expSum = '0;
   logic [31:0]       doneSum = '0;

   task automatic checkOutput(input string tag, input logic [LINE_W-1:0] observed,
                              input logic [LINE_W-1:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [BEAT_W-1:0] randBeat();
      logic [BEAT_W-1:0] b;
      for (int i = 0; i < BEAT_W; i += 32) b[i +: 32] = $urandom;
      return b;
   endfunction

   task automatic checkResetValues();
      checkOutput("rst_read", readOut, 0);
      checkOutput("rst_wr_valid", wrValid, 0);
      checkOutput("rst_wr_last", wrLast, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_wr_addr", wrAddr, 0);
      checkOutput("rst_wr_data", wrData, 0);
      checkOutput("rst_checksum", checksum, 0);
   endtask

   // Called at the falling edge, when inputs and outputs are both settled
   task automatic sampleOutputs();
      line_t e;
      rdSeen  = readOut;
      accSeen = wrValid && wrReady;
      checkOutput("read_rule", readOut, busy && !wrValid && !fifoEmpty);
      if (wrValid) begin
         validSeen = 1;
         if (prevHeld) begin
            checkOutput("hold_data", wrData, heldData);
            checkOutput("hold_addr", wrAddr, heldAddr);
         end
         if (wrReady) begin
            if (expQ.size() == 0) begin
               checkOutput("extra_line", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("line_data", wrData, e.data);
               checkOutput("line_addr", wrAddr, e.addr);
               checkOutput("line_last", wrLast, e.last);
            end
            wrCycles.push_back(cyc);
            prevHeld = 0;
         end else begin
            prevHeld = 1;
            heldData = wrData;
            heldAddr = wrAddr;
         end
      end else begin
         prevHeld = 0;
      end
      if (prevDone) begin
         checkOutput("done_width", done, 0);
         checkOutput("checksum_idle", checksum, doneSum);
      end
      if (done) begin
         doneCount++;
         lastDoneCyc = cyc;
         doneSum = expSum;
         checkOutput("lines_left", expQ.size(), 0);
         checkOutput("done_busy", busy, 0);
         checkOutput("done_checksum", checksum, expSum);
      end
      prevDone = done;
   endtask

   task automatic driveInputs();
      fifoEmpty = (fifoQ.size() == 0) || ($urandom_range(99) < stallPct);
      fifoData  = (fifoQ.size() != 0) ? fifoQ[0] : randBeat();
      if (wrValid && holdCnt < holdLen) begin
         wrReady = 1'b0;
         holdCnt++;
      end else begin
         wrReady = ($urandom_range(99) < readyPct);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      sampleOutputs();
      @(posedge clk);
      #1;
      cyc++;
      if (rdSeen && fifoQ.size() != 0) void'(fifoQ.pop_front());
      if (accSeen) holdCnt = 0;
      start = 1'b0;
      driveInputs();
   endtask

   // Builds the job's beats and the expected lines, starts the job and runs it to o_done
   task automatic applyStimulus(input logic [31:0] base, input int n, input bit pattern,
                                input bit extraStarts);
      logic [BEAT_W-1:0] beats[$];
      logic [BEAT_W-1:0] b;
      line_t             ln;
      int                budget;
      expSum = '0;
      for (int k = 0; k < n * LINE_BEATS; k++) begin
         if (pattern) begin
            for (int r = 0; r < P; r++) b[r*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(k * P + r);
         end else begin
            b = randBeat();
         end
         beats.push_back(b);
         fifoQ.push_back(b);
`ifdef MERGER_OUT_WRITER_CHECKSUM_EN
         for (int r = 0; r < P; r++) expSum = expSum + 32'(b[r*DATA_WIDTH +: DATA_WIDTH]);
`endif
      end
      for (int k = 0; k < n; k++) begin
         for (int j = 0; j < LINE_BEATS; j++) ln.data[j*BEAT_W +: BEAT_W] = beats[k*LINE_BEATS + j];
         ln.addr = base + 32'(k * ADDR_STEP);
         ln.last = ((k % BURST_SIZE) == BURST_SIZE - 1) || (k == n - 1);
         expQ.push_back(ln);
      end
      wrCycles.delete();
      doneCount = 0;
      validSeen = 0;
      start     = 1'b1;
      baseAddr  = base;
      numLines  = 32'(n);
      startCyc  = cyc;
      driveInputs();
      budget = n * LINE_BEATS * 12 + 60;
      for (int t = 0; t < budget && doneCount == 0; t++) begin
         tick();
         numLines = $urandom;
         baseAddr = $urandom;
         if (extraStarts && busy && $urandom_range(2) == 0) start = 1'b1;
      end
      if (doneCount == 0) checkOutput("timeout", 0, 1);
      checkOutput("done_count", doneCount, 1);
      checkOutput("fifo_drained", fifoQ.size(), 0);
   endtask

   initial begin
      logic [31:0] expPattern;
      rstN      = 1'b0;
      start     = 1'b0;
      baseAddr  = '0;
      numLines  = '0;
      fifoData  = '0;
      fifoEmpty = 1'b1;
      wrReady   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstN = 1'b1;
      @(negedge clk);
      checkResetValues();
      @(posedge clk);
      #1;
      cyc++;
      driveInputs();

      // Back-to-back timing of a clean two-line job
      stallPct = 0;
      readyPct = 100;
      applyStimulus(32'h100, 2, 1'b0, 1'b0);
      checkOutput("wr_count", wrCycles.size(), 2);
      if (wrCycles.size() >= 2) begin
         checkOutput("wr0_cycle", wrCycles[0] - startCyc, 5);
         checkOutput("wr1_cycle", wrCycles[1] - startCyc, 10);
      end
      checkOutput("done_cycle", lastDoneCyc - startCyc, 11);

      // Known record ordering and checksum
      applyStimulus(32'h400, 1, 1'b1, 1'b0);
`ifdef MERGER_OUT_WRITER_CHECKSUM_EN
      expPattern = 32'd120;
`else
      expPattern = 32'd0;
`endif
      checkOutput("pattern_checksum", checksum, expPattern);

      // Multi-burst job with random stalls and backpressure
      stallPct = 30;
      readyPct = 70;
      applyStimulus($urandom & 32'hFFFF_FFF0, 45, 1'b0, 1'b0);

      // Long backpressure on every line
      stallPct = 0;
      readyPct = 100;
      holdLen  = 7;
      applyStimulus(32'h8000, 3, 1'b0, 1'b0);
      holdLen  = 0;

      // Random empties with stray starts, then a zero-length job
      stallPct = 50;
      readyPct = 60;
      applyStimulus(32'h2_0000, 6, 1'b0, 1'b1);
      applyStimulus(32'h3_0000, 0, 1'b0, 1'b0);
      checkOutput("zero_done_cycle", lastDoneCyc - startCyc, 1);
      checkOutput("zero_no_valid", validSeen, 0);

      // Reset in the middle of a line discards the partial beats
      stallPct  = 0;
      readyPct  = 100;
      doneCount = 0;
      fifoQ.push_back(randBeat());
      fifoQ.push_back(randBeat());
      start    = 1'b1;
      baseAddr = 32'h5000;
      numLines = 32'd1;
      driveInputs();
      for (int t = 0; t < 10 && fifoQ.size() != 0; t++) tick();
      checkOutput("partial_fed", fifoQ.size(), 0);
      rstN = 1'b0;
      tick();
      rstN = 1'b1;
      @(negedge clk);
      checkResetValues();
      checkOutput("rst_no_done", doneCount, 0);
      prevDone = 0;
      prevHeld = 0;
      @(posedge clk);
      #1;
      cyc++;
      driveInputs();
      applyStimulus(32'h6000, 1, 1'b0, 1'b0);

      // Random jobs, one crossing the 32-bit address wrap
      stallPct = 25;
      readyPct = 75;
      applyStimulus(32'hFFFF_FFC0, 9, 1'b0, 1'b1);
      for (int j = 0; j < 3; j++) begin
         applyStimulus($urandom, $urandom_range(25, 1), 1'b0, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
